// File: rtl/object_spawn_scheduler.sv
// Spawn-pattern sequencer: walks the pattern ROM, waits per-entry centisecond delays, loads free object slots.
// Optional build macro SPAWN_DROP_ON_FULL_EN: discard entries when no slot is free and pulse drop_pulse.
module object_spawn_scheduler #(
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned SYNC_HOLD = 2
) (
    input  logic                 clk_calculation,
    input  logic                 reset,
    input  logic                 clk_centi_second,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [67:0]          rom_data,
    input  logic [NUM_SLOTS-1:0] slot_free,
    output logic [NUM_SLOTS-1:0] slot_sync_n,
    output logic [9:0]           spawn_pos_x,
    output logic [9:0]           spawn_pos_y,
    output logic [2:0]           spawn_dir,
    output logic [4:0]           spawn_speed,
    output logic [7:0]           spawn_destroy_time,
    output logic [1:0]           spawn_destroy_trigger,
    output logic [9:0]           spawn_w,
    output logic [9:0]           spawn_h,
    output logic                 busy,
    output logic                 pattern_done,
    output logic [7:0]           spawn_count
`ifdef SPAWN_DROP_ON_FULL_EN
    ,
    output logic                 drop_pulse
`endif
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned HOLD_W = $clog2(SYNC_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT_DELAY,
        FIND_SLOT,
        LOAD,
        NEXT
    } state_t;

    state_t state, state_d;

    logic [2:0]        centi_sync;
    logic              centi_tick;
    logic [7:0]        delay_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              entry_end;
    logic [SLOT_W-1:0] free_idx;
    logic              free_any;
    logic              delay_done;
    logic              skip_spawn;
    logic              hold_done;
    logic              abort;
    logic              unused_rsvd;

    assign unused_rsvd = rom_data[0];
    assign centi_tick  = centi_sync[1] & ~centi_sync[2];
    assign delay_done  = (delay_cnt == '0);
    assign skip_spawn  = entry_end && ((spawn_w == '0) || (spawn_h == '0));
    assign hold_done   = (hold_cnt == HOLD_W'(SYNC_HOLD - 1));
    assign abort       = stop && (state != IDLE);

    always_comb begin
        free_idx = '0;
        free_any = 1'b0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slot_free[i] && !free_any) begin
                free_idx = SLOT_W'(i);
                free_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (start && !stop) state_d = FETCH;
            FETCH:      state_d = LATCH;
            LATCH:      state_d = WAIT_DELAY;
            WAIT_DELAY: if (delay_done) state_d = skip_spawn ? NEXT : FIND_SLOT;
`ifdef SPAWN_DROP_ON_FULL_EN
            FIND_SLOT:  state_d = free_any ? LOAD : NEXT;
`else
            FIND_SLOT:  if (free_any) state_d = LOAD;
`endif
            LOAD:       if (hold_done) state_d = NEXT;
            NEXT:       state_d = entry_end ? IDLE : FETCH;
            default:    state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk_calculation or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk_calculation or negedge reset) begin
        if (!reset) begin
            centi_sync            <= '0;
            rom_addr              <= '0;
            slot_sync_n           <= '1;
            spawn_pos_x           <= '0;
            spawn_pos_y           <= '0;
            spawn_dir             <= '0;
            spawn_speed           <= '0;
            spawn_destroy_time    <= '0;
            spawn_destroy_trigger <= '0;
            spawn_w               <= '0;
            spawn_h               <= '0;
            busy                  <= 1'b0;
            pattern_done          <= 1'b0;
            spawn_count           <= '0;
            delay_cnt             <= '0;
            hold_cnt              <= '0;
            entry_end             <= 1'b0;
`ifdef SPAWN_DROP_ON_FULL_EN
            drop_pulse            <= 1'b0;
`endif
        end else begin
            centi_sync   <= {centi_sync[1:0], clk_centi_second};
            pattern_done <= 1'b0;
`ifdef SPAWN_DROP_ON_FULL_EN
            drop_pulse   <= 1'b0;
`endif
            if (abort) begin
                slot_sync_n  <= '1;
                busy         <= 1'b0;
                pattern_done <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            rom_addr    <= base_addr;
                            spawn_count <= '0;
                            busy        <= 1'b1;
                        end
                    end
                    LATCH: begin
                        entry_end             <= rom_data[67];
                        delay_cnt             <= rom_data[66:59];
                        spawn_pos_x           <= rom_data[58:49];
                        spawn_pos_y           <= rom_data[48:39];
                        spawn_dir             <= rom_data[38:36];
                        spawn_speed           <= rom_data[35:31];
                        spawn_destroy_time    <= rom_data[30:23];
                        spawn_destroy_trigger <= rom_data[22:21];
                        spawn_w               <= rom_data[20:11];
                        spawn_h               <= rom_data[10:1];
                    end
                    WAIT_DELAY: begin
                        // a tick arriving in the exit cycle is dropped, never carried over
                        if (!delay_done && centi_tick) delay_cnt <= delay_cnt - 1'b1;
                    end
                    FIND_SLOT: begin
                        if (free_any) begin
                            slot_sync_n <= ~(NUM_SLOTS'(1) << free_idx);
                            hold_cnt    <= '0;
                        end
`ifdef SPAWN_DROP_ON_FULL_EN
                        else begin
                            drop_pulse <= 1'b1;
                        end
`endif
                    end
                    LOAD: begin
                        if (hold_done) begin
                            slot_sync_n <= '1;
                            if (spawn_count != 8'hFF) spawn_count <= spawn_count + 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    NEXT: begin
                        if (entry_end) begin
                            busy         <= 1'b0;
                            pattern_done <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_object_spawn_scheduler.sv
// Directed self-checking bench for object_spawn_scheduler (default parameters).
module tb_object_spawn_scheduler;

    logic        clk_calculation = 1'b0;
    logic        reset;
    logic        clk_centi_second;
    logic        start;
    logic        stop;
    logic [7:0]  base_addr;
    logic [7:0]  rom_addr;
    logic [67:0] rom_data;
    logic [7:0]  slot_free;
    logic [7:0]  slot_sync_n;
    logic [9:0]  spawn_pos_x, spawn_pos_y, spawn_w, spawn_h;
    logic [2:0]  spawn_dir;
    logic [4:0]  spawn_speed;
    logic [7:0]  spawn_destroy_time;
    logic [1:0]  spawn_destroy_trigger;
    logic        busy, pattern_done;
    logic [7:0]  spawn_count;
`ifdef SPAWN_DROP_ON_FULL_EN
    logic        drop_pulse;
`endif

    int checks = 0;
    int errors = 0;
    int lat;
    logic seen_low;

    logic [67:0] rom [256];

    object_spawn_scheduler #(.NUM_SLOTS(8), .ADDR_W(8), .SYNC_HOLD(2)) dut (
        .clk_calculation      (clk_calculation),
        .reset                (reset),
        .clk_centi_second     (clk_centi_second),
        .start                (start),
        .stop                 (stop),
        .base_addr            (base_addr),
        .rom_addr             (rom_addr),
        .rom_data             (rom_data),
        .slot_free            (slot_free),
        .slot_sync_n          (slot_sync_n),
        .spawn_pos_x          (spawn_pos_x),
        .spawn_pos_y          (spawn_pos_y),
        .spawn_dir            (spawn_dir),
        .spawn_speed          (spawn_speed),
        .spawn_destroy_time   (spawn_destroy_time),
        .spawn_destroy_trigger(spawn_destroy_trigger),
        .spawn_w              (spawn_w),
        .spawn_h              (spawn_h),
        .busy                 (busy),
        .pattern_done         (pattern_done),
        .spawn_count          (spawn_count)
`ifdef SPAWN_DROP_ON_FULL_EN
        ,
        .drop_pulse           (drop_pulse)
`endif
    );

    always #5 clk_calculation = ~clk_calculation;

    // synchronous ROM: data valid one cycle after the address
    always @(posedge clk_calculation) rom_data <= rom[rom_addr];

    function automatic logic [67:0] ent(input logic e, input logic [7:0] d,
                                        input logic [9:0] x, input logic [9:0] y,
                                        input logic [2:0] dir, input logic [4:0] sp,
                                        input logic [7:0] dt, input logic [1:0] tr,
                                        input logic [9:0] w, input logic [9:0] h);
        return {e, d, x, y, dir, sp, dt, tr, w, h, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_calculation);
        #1;
    endtask

    task automatic start_pattern(input logic [7:0] addr);
        base_addr = addr;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_sync_low(input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (slot_sync_n === 8'hFF && n < bound);
    endtask

    task automatic wait_done(input int bound, output int n, output logic low);
        n = 0;
        low = 1'b0;
        do begin
            cyc();
            n++;
            if (slot_sync_n !== 8'hFF) low = 1'b1;
        end while (pattern_done !== 1'b1 && n < bound);
    endtask

    task automatic centi_pulse();
        clk_centi_second = 1'b1;
        repeat (4) cyc();
        clk_centi_second = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rom[8'h10] = ent(1'b1, 8'd0, 10'd100, 10'd50, 3'd2, 5'd4, 8'h20, 2'd1, 10'd16, 10'd12);
        rom[8'h20] = ent(1'b0, 8'd3, 10'd1, 10'd2, 3'd1, 5'd1, 8'h01, 2'd0, 10'd4, 10'd4);
        rom[8'h21] = ent(1'b1, 8'd0, 10'd3, 10'd4, 3'd3, 5'd2, 8'h02, 2'd2, 10'd4, 10'd4);
        rom[8'h30] = ent(1'b0, 8'd0, 10'd7, 10'd8, 3'd0, 5'd3, 8'h05, 2'd0, 10'd8, 10'd8);
        rom[8'h31] = ent(1'b1, 8'd0, 10'd0, 10'd0, 3'd0, 5'd0, 8'h00, 2'd0, 10'd0, 10'd0);
        rom[8'h40] = ent(1'b0, 8'd0, 10'd1, 10'd1, 3'd1, 5'd1, 8'h01, 2'd1, 10'd2, 10'd2);
        rom[8'h41] = ent(1'b0, 8'd0, 10'd2, 10'd2, 3'd2, 5'd2, 8'h02, 2'd2, 10'd2, 10'd2);
        rom[8'h42] = ent(1'b0, 8'd5, 10'd3, 10'd3, 3'd3, 5'd3, 8'h03, 2'd3, 10'd2, 10'd2);
        rom[8'h43] = ent(1'b0, 8'd0, 10'd4, 10'd4, 3'd4, 5'd4, 8'h04, 2'd0, 10'd2, 10'd2);
        rom[8'h44] = ent(1'b1, 8'd0, 10'd5, 10'd5, 3'd5, 5'd5, 8'h05, 2'd1, 10'd2, 10'd2);

        reset = 1'b0;
        clk_centi_second = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        base_addr = '0;
        slot_free = 8'hFF;
        repeat (3) cyc();
        check("rst_sync_n", slot_sync_n, 8'hFF);
        check("rst_busy", busy, 1'b0);
        check("rst_done", pattern_done, 1'b0);
        check("rst_rom_addr", rom_addr, 8'h00);
        check("rst_count", spawn_count, 8'h00);
        check("rst_pos_x", spawn_pos_x, 10'd0);
        reset = 1'b1;
        cyc();

        // single end entry, no delay, all slots free
        start_pattern(8'h10);
        check("t1_rom_addr", rom_addr, 8'h10);
        check("t1_busy", busy, 1'b1);
        wait_sync_low(20, lat);
        check("t1_load_lat", lat, 4);
        check("t1_sync0", slot_sync_n, 8'hFE);
        check("t1_x", spawn_pos_x, 10'd100);
        check("t1_y", spawn_pos_y, 10'd50);
        check("t1_dir", spawn_dir, 3'd2);
        check("t1_speed", spawn_speed, 5'd4);
        check("t1_dt", spawn_destroy_time, 8'h20);
        check("t1_trig", spawn_destroy_trigger, 2'd1);
        check("t1_w", spawn_w, 10'd16);
        check("t1_h", spawn_h, 10'd12);
        cyc();
        check("t1_sync1", slot_sync_n, 8'hFE);
        cyc();
        check("t1_release", slot_sync_n, 8'hFF);
        check("t1_count", spawn_count, 8'd1);
        check("t1_done_early", pattern_done, 1'b0);
        cyc();
        check("t1_done", pattern_done, 1'b1);
        check("t1_busy_off", busy, 1'b0);
        cyc();
        check("t1_done_pulse", pattern_done, 1'b0);
        check("t1_x_hold", spawn_pos_x, 10'd100);

        // delay=3 entry, then delay=0 entry into slot 4
        start_pattern(8'h20);
        repeat (2) cyc();
        centi_pulse();
        centi_pulse();
        check("t2_no_early_load", slot_sync_n, 8'hFF);
        clk_centi_second = 1'b1;
        wait_sync_low(12, lat);
        clk_centi_second = 1'b0;
        check("t2_tick3_lat", lat, 5);
        check("t2_sync", slot_sync_n, 8'hFE);
        slot_free = 8'b1111_0000;
        repeat (2) cyc();
        check("t2_release", slot_sync_n, 8'hFF);
        check("t2_count1", spawn_count, 8'd1);
        wait_sync_low(12, lat);
        check("t2_delay0_lat", lat, 5);
        check("t2_slot4", slot_sync_n, 8'hEF);
        check("t2_rom_addr", rom_addr, 8'h21);
        check("t2_x", spawn_pos_x, 10'd3);
        wait_done(20, lat, seen_low);
        check("t2_done", pattern_done, 1'b1);
        check("t2_count2", spawn_count, 8'd2);
        cyc();

        // no free slot, then slot 2 frees; final end entry carries no object
        slot_free = 8'h00;
        start_pattern(8'h30);
`ifdef SPAWN_DROP_ON_FULL_EN
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (drop_pulse !== 1'b1 && lat < 20);
        check("t3_drop", drop_pulse, 1'b1);
        wait_done(20, lat, seen_low);
        check("t3_done", pattern_done, 1'b1);
        check("t3_no_load", seen_low, 1'b0);
        check("t3_count", spawn_count, 8'd0);
        check("t3_rom_addr", rom_addr, 8'h31);
`else
        repeat (50) cyc();
        check("t3_stall_sync", slot_sync_n, 8'hFF);
        check("t3_stall_busy", busy, 1'b1);
        slot_free = 8'b0000_0100;
        wait_sync_low(5, lat);
        check("t3_free_lat", lat, 1);
        check("t3_slot2", slot_sync_n, 8'hFB);
        wait_done(20, lat, seen_low);
        check("t3_done", pattern_done, 1'b1);
        check("t3_count", spawn_count, 8'd1);
        check("t3_rom_addr", rom_addr, 8'h31);
`endif
        cyc();

        // stop during the delay of entry 3 of 5
        slot_free = 8'hFF;
        start_pattern(8'h40);
        wait_sync_low(10, lat);
        check("t4_load1_lat", lat, 4);
        repeat (2) cyc();
        wait_sync_low(10, lat);
        check("t4_load2_lat", lat, 5);
        repeat (2) cyc();
        repeat (3) cyc();
        check("t4_rom_addr", rom_addr, 8'h42);
        repeat (2) cyc();
        check("t4_waiting", slot_sync_n, 8'hFF);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("t4_done", pattern_done, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_count", spawn_count, 8'd2);
        repeat (10) cyc();
        check("t4_rom_frozen", rom_addr, 8'h42);
        check("t4_done_pulse", pattern_done, 1'b0);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        check("t4_stop_wins", busy, 1'b0);
        cyc();
        check("t4_rom_still", rom_addr, 8'h42);

        // asynchronous reset in the middle of a load
        start_pattern(8'h10);
        wait_sync_low(20, lat);
        check("t5_loading", slot_sync_n, 8'hFE);
        reset = 1'b0;
        #1;
        check("t5_async_sync", slot_sync_n, 8'hFF);
        check("t5_async_busy", busy, 1'b0);
        check("t5_async_count", spawn_count, 8'd0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/object_spawn_scheduler.md
Name: object_spawn_scheduler

Overview:
Upstream feeder for the per-slot object position controllers. Walks a spawn-pattern ROM and waits each entry's centisecond delay. Finds the lowest-index free object slot, then loads that slot by driving the shared spawn bus and pulsing the slot's active-low sync line. One instance per attack pattern engine, running in the calculation clock domain.

Parameters:
NUM_SLOTS, 8, number of object slots (position controllers) served
ADDR_W, 8, pattern ROM address width
SYNC_HOLD, 2, cycles a slot's sync line is held low during load (min 1)

Ports:
clk_calculation  in  1  block clock
reset  in  1  asynchronous, active-low reset
clk_centi_second  in  1  centisecond clock; sampled through a 2-flop synchroniser, rising edge = tick
start  in  1  1-cycle pulse, begin pattern at base_addr
stop  in  1  1-cycle pulse, abort pattern
base_addr  in  ADDR_W  first ROM entry of pattern
rom_addr  out  ADDR_W  ROM read address
rom_data  in  68  ROM entry, valid 1 cycle after rom_addr
slot_free  in  NUM_SLOTS  object_free of each slot
slot_sync_n  out  NUM_SLOTS  active-low load strobe per slot (drives sync_object_position)
spawn_pos_x, spawn_pos_y  out  10 each  start position
spawn_dir  out  3  movement direction
spawn_speed  out  5  speed
spawn_destroy_time  out  8  destroy time
spawn_destroy_trigger  out  2  destroy trigger
spawn_w, spawn_h  out  10 each  object size
busy  out  1  pattern in progress
pattern_done  out  1  1-cycle pulse, end entry issued or stop taken
spawn_count  out  8  entries issued since start, saturating at 255

Behaviour:
- Entry fields:
  - end [67]
  - delay [66:59]
  - x [58:49]
  - y [48:39]
  - dir [38:36]
  - speed [35:31]
  - destroy_time [30:23]
  - trigger [22:21]
  - w [20:11]
  - h [10:1]
  - bit 0 reserved, ignored.
- Reset values: slot_sync_n all 1; spawn bus 0; rom_addr 0; busy 0; pattern_done 0; spawn_count 0; FSM IDLE; synchroniser flops 0.
- FSM states: IDLE, FETCH, LATCH, WAIT_DELAY, FIND_SLOT, LOAD, NEXT.
- IDLE:
  - start -> rom_addr=base_addr, spawn_count=0, busy=1, go to FETCH.
  - start while not IDLE is ignored.
- FETCH: one wait cycle for ROM latency -> LATCH.
- LATCH:
  - Register all entry fields onto the spawn bus; load delay counter with delay.
  - Go to WAIT_DELAY.
- WAIT_DELAY:
  - Decrement delay counter on each centi tick.
  - Leave when counter==0, so delay=0 proceeds on the next cycle; delay=N waits N ticks.
  - If end=1 and the entry carries no object (w==0 or h==0): skip the spawn and go to NEXT.
- FIND_SLOT:
  - Pick the lowest index i with slot_free[i]=1 -> LOAD.
  - No free slot -> stay in FIND_SLOT (stall); see optional feature.
- LOAD:
  - Drive slot_sync_n[i]=0 for exactly SYNC_HOLD cycles; all other bits stay 1.
  - Spawn bus stays stable through LOAD and 1 cycle after.
  - Then release slot_sync_n[i] and increment spawn_count (saturating) -> NEXT.
- NEXT:
  - If the entry had end=1: busy=0, pattern_done=1 for 1 cycle, go to IDLE.
  - Otherwise rom_addr+1 (wraps at 2^ADDR_W) -> FETCH.
- Never more than one slot_sync_n bit low at once.
- stop in any non-IDLE state:
  - Next cycle all slot_sync_n=1, busy=0, pattern_done pulse, go to IDLE.
  - A slot mid-LOAD is abandoned. Its controller already saw sync low and holds the latched values.
  - stop and start in the same cycle: stop wins.
- Slot chosen in FIND_SLOT is latched; slot_free changes during LOAD are ignored.
- Centi tick coinciding with a state exit is dropped; no accumulation.

Optional Feature:
SPAWN_DROP_ON_FULL_EN
- Defined: FIND_SLOT with no free slot discards the entry, goes to NEXT without loading, and pulses output drop_pulse (1 bit, reset 0).
- Undefined: FIND_SLOT stalls until a slot frees; drop_pulse port absent.

Test Plan:
- Reset low mid-LOAD -> slot_sync_n=8'hFF, busy=0 immediately (asynchronous).
- Entry x=100, y=50, dir=2, speed=4, delay=0, end=1, all slots free, start -> slot_sync_n=8'hFE for 2 cycles, spawn bus shows 100/50/2/4, pattern_done 1 cycle after release, spawn_count=1.
- Entry delay=3 -> slot load begins 3 centi ticks after LATCH, not earlier; delay=0 entry follows with no tick wait.
- slot_free=8'b1111_0000 -> slot_sync_n=8'hEF (slot 4 loaded).
- slot_free=0 for 50 cycles then bit 2 set -> stalls, then loads slot 2; with SPAWN_DROP_ON_FULL_EN -> drop_pulse, next entry fetched, no load.
- stop asserted during WAIT_DELAY of entry 3 of 5 -> pattern_done pulse, busy=0, spawn_count=2, no further rom_addr change.
